rv32im_lsu: RTL and testbench

RV32IM_LSU -- requirements
Module: rv32im_lsu

---
 rtl/rv32im_lsu_pkg.sv | 54 +++++
 rtl/rv32im_lsu_load_fmt.sv | 34 +++
 rtl/rv32im_lsu.sv | 98 +++++++++
 tb/tb_rv32im_lsu.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32im_lsu_pkg.sv
// ============================================================================
// Module      : rv32im_lsu_pkg
// Description : Opcode encodings, widths and decode helpers for the RV32IM LSU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32im_lsu_pkg;

    localparam int c_DATA_WIDTH = 32;
    localparam int c_OPC_WIDTH  = 4;

    typedef logic [c_OPC_WIDTH-1:0] opcode_t;

    localparam opcode_t c_OP_NONE = 4'b0000;
    localparam opcode_t c_OP_LB   = 4'b0001;
    localparam opcode_t c_OP_LH   = 4'b0010;
    localparam opcode_t c_OP_LW   = 4'b0011;
    localparam opcode_t c_OP_LBU  = 4'b0100;
    localparam opcode_t c_OP_LHU  = 4'b0101;
    localparam opcode_t c_OP_SB   = 4'b1001;
    localparam opcode_t c_OP_SH   = 4'b1010;
    localparam opcode_t c_OP_SW   = 4'b1011;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } size_e;

    function automatic logic is_load(input opcode_t op);
        return (op == c_OP_LB) || (op == c_OP_LH) || (op == c_OP_LW) ||
               (op == c_OP_LBU) || (op == c_OP_LHU);
    endfunction

    function automatic logic is_store(input opcode_t op);
        return (op == c_OP_SB) || (op == c_OP_SH) || (op == c_OP_SW);
    endfunction

    function automatic size_e access_size(input opcode_t op);
        size_e sz;
        case (op)
            c_OP_LB, c_OP_LBU, c_OP_SB: sz = SZ_BYTE;
            c_OP_LH, c_OP_LHU, c_OP_SH: sz = SZ_HALF;
            c_OP_LW, c_OP_SW:           sz = SZ_WORD;
            default:                    sz = SZ_NONE;
        endcase
        return sz;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rv32im_lsu_load_fmt.sv
// ============================================================================
// Module      : rv32im_lsu_load_fmt
// Description : Combinational load-result alignment and sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32im_lsu_load_fmt
    import rv32im_lsu_pkg::*;
(
    input  logic [c_DATA_WIDTH-1:0] i_word,
    input  logic [1:0]              i_off,
    input  opcode_t                 i_opcode,
    output logic [c_DATA_WIDTH-1:0] o_data
);

    logic [c_DATA_WIDTH-1:0] w_shifted;

    always_comb begin
        w_shifted = i_word >> {i_off, 3'b000};
        o_data    = '0;
        case (i_opcode)
            c_OP_LB:  o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            c_OP_LBU: o_data = {24'd0, w_shifted[7:0]};
            c_OP_LH:  o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            c_OP_LHU: o_data = {16'd0, w_shifted[15:0]};
            c_OP_LW:  o_data = i_word;
            default:  o_data = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/rv32im_lsu.sv
// ============================================================================
// Module      : rv32im_lsu
// Description : RV32IM load/store unit: byte-lane request generation and
//               one-cycle-latency load formatting. Optional misalignment
//               trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32im_lsu
    import rv32im_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int OPC_WIDTH  = c_OPC_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [OPC_WIDTH-1:0]    lsu_opcode_i,
    input  logic [DATA_WIDTH-1:0]   addr_mem_i,
    input  logic [DATA_WIDTH-1:0]   val_memwr_i,
    input  logic [DATA_WIDTH-1:0]   val_memrd_i,
    output logic [DATA_WIDTH-1:0]   addr_mem_o,
    output logic [DATA_WIDTH-1:0]   val_memwr_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic                    mem_we_o,
    output logic                    mem_re_o,
    output logic [DATA_WIDTH-1:0]   val_memrd_o,
    output logic                    rd_valid_o,
    output logic                    misaligned_o
);

    logic [1:0]              w_off;
    logic [1:0]              w_eff_off;
    logic                    w_block;
    size_e                   w_size;
    logic [DATA_WIDTH-1:0]   w_fmt;
    opcode_t                 r_opcode;
    logic [1:0]              r_off;

    assign w_off      = addr_mem_i[1:0];
    assign w_size     = access_size(lsu_opcode_i);
    assign addr_mem_o = {addr_mem_i[DATA_WIDTH-1:2], 2'b00};

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned_o = ((w_size == SZ_HALF) && w_off[0]) ||
                          ((w_size == SZ_WORD) && (w_off != 2'b00));
    assign w_block      = misaligned_o;
    assign w_eff_off    = w_off;
`else
    // Without trapping, offset bits the access size cannot use are dropped.
    assign misaligned_o = 1'b0;
    assign w_block      = 1'b0;
    always_comb begin
        w_eff_off = w_off;
        if (w_size == SZ_HALF) w_eff_off = {w_off[1], 1'b0};
        else if (w_size == SZ_WORD) w_eff_off = 2'b00;
    end
`endif

    always_comb begin
        mem_be_o = '0;
        case (w_size)
            SZ_BYTE: mem_be_o = 4'b0001 << w_eff_off;
            SZ_HALF: mem_be_o = 4'b0011 << w_eff_off;
            SZ_WORD: mem_be_o = 4'b1111;
            default: mem_be_o = '0;
        endcase
        if (w_block) mem_be_o = '0;
    end

    assign mem_we_o    = is_store(lsu_opcode_i) && !w_block;
    assign mem_re_o    = is_load(lsu_opcode_i) && !w_block;
    assign val_memwr_o = is_store(lsu_opcode_i) ? (val_memwr_i << {w_eff_off, 3'b000}) : '0;

    // Only issued loads are captured, so blocked or store requests never raise rd_valid_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_opcode <= c_OP_NONE;
            r_off    <= 2'b00;
        end else begin
            r_opcode <= mem_re_o ? lsu_opcode_i : c_OP_NONE;
            r_off    <= w_eff_off;
        end
    end

    rv32im_lsu_load_fmt u_load_fmt (
        .i_word   (val_memrd_i),
        .i_off    (r_off),
        .i_opcode (r_opcode),
        .o_data   (w_fmt)
    );

    assign rd_valid_o  = is_load(r_opcode);
    assign val_memrd_o = rd_valid_o ? w_fmt : '0;

endmodule

`default_nettype wire

// File: tb/tb_rv32im_lsu.sv
// ============================================================================
// Module      : tb_rv32im_lsu
// Description : Directed self-checking bench for rv32im_lsu.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv32im_lsu;

    logic        clk;
    logic        rst_n;
    logic [3:0]  opcode;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic [31:0] rdata_in;
    logic [31:0] addr_out;
    logic [31:0] wdata_out;
    logic [3:0]  be;
    logic        we;
    logic        re;
    logic [31:0] rdata_out;
    logic        rd_valid;
    logic        misaligned;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [3:0] OP_NONE = 4'b0000, OP_LB = 4'b0001, OP_LH = 4'b0010,
                           OP_LW = 4'b0011, OP_LBU = 4'b0100, OP_LHU = 4'b0101,
                           OP_SB = 4'b1001, OP_SH = 4'b1010, OP_SW = 4'b1011;
    localparam logic [31:0] WORD = 32'h000C_F5BD;

    rv32im_lsu dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .lsu_opcode_i (opcode),
        .addr_mem_i   (addr_in),
        .val_memwr_i  (wdata_in),
        .val_memrd_i  (rdata_in),
        .addr_mem_o   (addr_out),
        .val_memwr_o  (wdata_out),
        .mem_be_o     (be),
        .mem_we_o     (we),
        .mem_re_o     (re),
        .val_memrd_o  (rdata_out),
        .rd_valid_o   (rd_valid),
        .misaligned_o (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s did not match", tag);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd);
        opcode   = op;
        addr_in  = a;
        wdata_in = wd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        opcode   = OP_NONE;
        addr_in  = '0;
        wdata_in = '0;
        rdata_in = WORD;
        #12;
        check("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("reset_rdata", rdata_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // LW addr 0
        issue(OP_LW, 32'h0, 32'h0);
        check("lw_re", {31'd0, re}, 32'd1);
        check("lw_we", {31'd0, we}, 32'd0);
        check("lw_be", {28'd0, be}, 32'hF);
        check("lw_addr", addr_out, 32'h0);
        check("lw_wdata", wdata_out, 32'h0);
        tick();
        // Back-to-back: LB issued while LW result is observed
        issue(OP_LB, 32'h0, 32'h0);
        check("lw_valid", {31'd0, rd_valid}, 32'd1);
        check("lw_data", rdata_out, 32'h000C_F5BD);
        check("lb_be", {28'd0, be}, 32'h1);
        tick();
        issue(OP_LBU, 32'h0, 32'h0);
        check("lb_data", rdata_out, 32'hFFFF_FFBD);
        tick();
        issue(OP_LB, 32'h1, 32'h0);
        check("lbu_data", rdata_out, 32'h0000_00BD);
        check("lb1_be", {28'd0, be}, 32'h2);
        tick();
        issue(OP_LBU, 32'h6, 32'h0);
        check("lb1_data", rdata_out, 32'hFFFF_FFF5);
        check("lbu2_addr", addr_out, 32'h4);
        tick();
        issue(OP_LH, 32'h0, 32'h0);
        check("lbu2_data", rdata_out, 32'h0000_000C);
        check("lh_be", {28'd0, be}, 32'h3);
        tick();
        issue(OP_LHU, 32'h2, 32'h0);
        check("lh_data", rdata_out, 32'hFFFF_F5BD);
        check("lhu_be", {28'd0, be}, 32'hC);
        tick();
        issue(OP_SB, 32'h103, 32'h0000_00AA);
        check("lhu_data", rdata_out, 32'h0000_000C);
        check("sb_addr", addr_out, 32'h100);
        check("sb_be", {28'd0, be}, 32'h8);
        check("sb_wdata", wdata_out, 32'hAA00_0000);
        check("sb_we", {31'd0, we}, 32'd1);
        check("sb_re", {31'd0, re}, 32'd0);
        tick();
        issue(OP_SH, 32'h2, 32'h0000_1234);
        check("sb_no_valid", {31'd0, rd_valid}, 32'd0);
        check("sb_no_data", rdata_out, 32'd0);
        check("sh_be", {28'd0, be}, 32'hC);
        check("sh_wdata", wdata_out, 32'h1234_0000);
        tick();
        issue(OP_SW, 32'h8, 32'hDEAD_BEEF);
        check("sw_be", {28'd0, be}, 32'hF);
        check("sw_wdata", wdata_out, 32'hDEAD_BEEF);
        tick();
        issue(4'b0111, 32'h0, 32'h0);
        check("bad_op_be", {28'd0, be}, 32'h0);
        check("bad_op_re_we", {30'd0, re, we}, 32'd0);
        tick();
        check("bad_op_no_valid", {31'd0, rd_valid}, 32'd0);

        // Misaligned word load
        issue(OP_LW, 32'h2, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis_flag", {31'd0, misaligned}, 32'd1);
        check("mis_re", {31'd0, re}, 32'd0);
        check("mis_be", {28'd0, be}, 32'h0);
        tick();
        issue(OP_NONE, 32'h0, 32'h0);
        check("mis_no_valid", {31'd0, rd_valid}, 32'd0);
`else
        check("mis_flag", {31'd0, misaligned}, 32'd0);
        check("mis_re", {31'd0, re}, 32'd1);
        check("mis_be", {28'd0, be}, 32'hF);
        tick();
        issue(OP_LH, 32'h1, 32'h0);
        check("mis_lw_data", rdata_out, 32'h000C_F5BD);
        check("mis_lh_be", {28'd0, be}, 32'h3);
        tick();
        issue(OP_NONE, 32'h0, 32'h0);
        check("mis_lh_data", rdata_out, 32'hFFFF_F5BD);
`endif
        tick();

        // Reset while a load result is pending/visible
        issue(OP_LW, 32'h0, 32'h0);
        tick();
        check("pre_rst_valid", {31'd0, rd_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_valid_now", {31'd0, rd_valid}, 32'd0);
        check("rst_data_now", rdata_out, 32'd0);
        check("rst_comb_re", {31'd0, re}, 32'd1);
        @(negedge clk);
        issue(OP_NONE, 32'h0, 32'h0);
        rst_n = 1'b1;
        tick();
        check("post_rst_valid", {31'd0, rd_valid}, 32'd0);

        // Reset asserted before the edge that would capture the load
        issue(OP_LW, 32'h0, 32'h0);
        #2;
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        issue(OP_NONE, 32'h0, 32'h0);
        rst_n = 1'b1;
        check("cancel_valid", {31'd0, rd_valid}, 32'd0);
        tick();
        check("cancel_valid2", {31'd0, rd_valid}, 32'd0);
        check("cancel_data", rdata_out, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
